// File: rtl/detect_pkg.sv
// Shared defaults and helpers for the detect_event_logger block and its FIFO.
package detect_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; occupancy tracked in a level
// register so full/empty never depend on pointer comparison.
module sync_fifo_fwft
    import detect_pkg::*;
#(
    parameter int WIDTH = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == FULL_LVL);
    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_level = r_level;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush and reset empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

    // Storage write; stale words are harmless because the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps every detect pulse into a FWFT FIFO and keeps saturating
// event/drop counters with a sticky overflow flag.
module detect_event_logger
    import detect_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    input  logic                     clr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TS_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         evt_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow
);

    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_evt_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_drop;

    assign rd_valid = !w_empty;
    assign w_pop    = rd_valid && rd_ready;
    assign w_drop   = det_in && w_full && !w_pop;
    assign evt_cnt  = r_evt_cnt;
    assign drop_cnt = r_drop_cnt;
    assign overflow = r_overflow;

    sync_fifo_fwft #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (clr),
        .i_push  (det_in),
        .i_data  (r_ts),
        .i_pop   (rd_ready),
        .o_data  (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Free-running timestamp; wraps silently and ignores clr.
    always_ff @(posedge clk) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + 1'b1;
    end

    // Event/drop statistics; clr wins over a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_evt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (det_in) begin
            r_evt_cnt <= CNT_W'(sat_inc(64'(r_evt_cnt), CNT_W));
            if (w_drop) begin
                r_drop_cnt <= CNT_W'(sat_inc(64'(r_drop_cnt), CNT_W));
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
